// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter:
// owner tags, arbiter state encoding and access size codes.
package sram_arb_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order owner-tag FIFO: one bit per accepted address phase, popped as
// each response returns, so responses can be routed to their issuer.
module owner_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          push_tag,
    input  logic          pop,
    output logic          pop_tag,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] tags;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_tag = tags[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction-fetch and data requesters.
// The grant is locked once an address phase stalls, and responses are routed
// back in issue order via the owner FIFO.
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration in ARB_IDLE
// instead of fixed data-over-inst priority.
//
// state    | meaning
// ARB_IDLE | no stalled address phase; grant chosen combinationally
// ARB_INST | inst address phase stalled; grant held on inst
// ARB_DATA | data address phase stalled; grant held on data
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int OWNER_FIFO_AW   = $clog2(MAX_OUTSTANDING)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] pending_cnt
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        win_owner;
    logic        grant_owner;
    logic        granted_req;
    logic        accept;
    logic        pop;
    logic        head_owner;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

`ifdef SRAM_ARB_RR_EN
    logic last_owner;

    // Remember who won the last accepted address phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     last_owner <= OWNER_INST;
        else if (accept) last_owner <= grant_owner;
    end

    // Round-robin: on contention, favour the requester that did not win last.
    always_comb begin
        if (inst_req && data_req) win_owner = ~last_owner;
        else if (data_req)        win_owner = OWNER_DATA;
        else                      win_owner = OWNER_INST;
    end
`else
    // Fixed priority: data wins over inst.
    always_comb begin
        win_owner = data_req ? OWNER_DATA : OWNER_INST;
    end
`endif

    // Arbiter state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

    // Next state: lock onto the winner while its address phase is stalled.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (granted_req && !accept)
                          state_nxt = (grant_owner == OWNER_DATA) ? ARB_DATA : ARB_INST;
            ARB_INST,
            ARB_DATA: if (accept) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Grant selection, memory port drive and handshake routing.
    always_comb begin
        case (state)
            ARB_INST: grant_owner = OWNER_INST;
            ARB_DATA: grant_owner = OWNER_DATA;
            default:  grant_owner = win_owner;
        endcase
        granted_req = (grant_owner == OWNER_DATA) ? data_req : inst_req;
        // resetn gate keeps the port quiet for the whole reset, not just after an edge.
        mem_req     = resetn && granted_req && !fifo_full;
        accept      = mem_req && mem_addr_ok;
        if (grant_owner == OWNER_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wstrb = inst_wstrb;
            mem_wdata = inst_wdata;
        end
        inst_addr_ok = accept && (grant_owner == OWNER_INST);
        data_addr_ok = accept && (grant_owner == OWNER_DATA);
        pop          = mem_data_ok && !fifo_empty;
        inst_data_ok = pop && (head_owner == OWNER_INST);
        data_data_ok = pop && (head_owner == OWNER_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : inst_rdata_q;
        data_rdata   = data_data_ok ? mem_rdata : data_rdata_q;
    end

    // Each requester's rdata holds its last delivered value between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (inst_data_ok) inst_rdata_q <= mem_rdata;
            if (data_data_ok) data_rdata_q <= mem_rdata;
        end
    end

    // A response with nothing outstanding is dropped; flag it in simulation.
    always_ff @(posedge clk) begin
        if (resetn)
            assert (!(mem_data_ok && fifo_empty))
                else $warning("sram_bus_arbiter: mem_data_ok with no outstanding transaction ignored");
    end

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .AW    (OWNER_FIFO_AW),
        .CW    (CW)
    ) u_owner_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (accept),
        .push_tag (grant_owner),
        .pop      (pop),
        .pop_tag  (head_owner),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending_cnt)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter. Inputs change just after the falling
// edge and outputs are sampled 1 ns later, mid-cycle.
module tb_sram_bus_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  pending_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .pending_cnt(pending_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic quiet();
        inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = SIZE_W; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    initial begin
        quiet();
        resetn = 0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_cnt", 32'(pending_cnt), 0);
        chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
        step(); resetn = 1;

        // Single read from inst.
        step(); inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1; #1;
        chk("rd_mem_req", 32'(mem_req), 1);
        chk("rd_mem_addr", mem_addr, 32'h1C00_0000);
        chk("rd_inst_addr_ok", 32'(inst_addr_ok), 1);
        chk("rd_data_addr_ok", 32'(data_addr_ok), 0);
        chk("rd_cnt0", 32'(pending_cnt), 0);
        step(); inst_req = 0; mem_addr_ok = 0; #1;
        chk("rd_cnt1", 32'(pending_cnt), 1);
        chk("rd_addr_ok_pulse", 32'(inst_addr_ok), 0);
        step(); mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("rd_inst_data_ok", 32'(inst_data_ok), 1);
        chk("rd_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
        chk("rd_data_silent", {31'd0, data_data_ok}, 0);
        chk("rd_data_rdata", data_rdata, 0);
        step(); mem_data_ok = 0; mem_rdata = 0; #1;
        chk("rd_data_ok_pulse", 32'(inst_data_ok), 0);
        chk("rd_rdata_hold", inst_rdata, 32'hDEAD_BEEF);
        chk("rd_cnt_back", 32'(pending_cnt), 0);

        // Conflict: data wins, inst follows; responses in issue order.
        step(); inst_req = 1; inst_addr = 32'h1C00_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wstrb = 4'hF;
        data_wdata = 32'h1234_5678; mem_addr_ok = 1; #1;
        chk("cf_mem_addr_data", mem_addr, 32'h8000_0010);
        chk("cf_mem_wr", 32'(mem_wr), 1);
        chk("cf_mem_wstrb", 32'(mem_wstrb), 32'hF);
        chk("cf_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("cf_data_addr_ok", 32'(data_addr_ok), 1);
        chk("cf_inst_addr_ok0", 32'(inst_addr_ok), 0);
        step(); data_req = 0; data_wr = 0; #1;
        chk("cf_mem_addr_inst", mem_addr, 32'h1C00_0004);
        chk("cf_inst_addr_ok", 32'(inst_addr_ok), 1);
        chk("cf_cnt1", 32'(pending_cnt), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_AAAA; #1;
        chk("cf_cnt2", 32'(pending_cnt), 2);
        chk("cf_first_resp", {30'd0, data_data_ok, inst_data_ok}, 32'b10);
        chk("cf_data_rdata", data_rdata, 32'h0000_AAAA);
        step(); mem_rdata = 32'h0000_BBBB; #1;
        chk("cf_second_resp", {30'd0, data_data_ok, inst_data_ok}, 32'b01);
        chk("cf_inst_rdata", inst_rdata, 32'h0000_BBBB);
        chk("cf_data_rdata_hold", data_rdata, 32'h0000_AAAA);
        step(); mem_data_ok = 0; #1;
        chk("cf_cnt0", 32'(pending_cnt), 0);

        // Lock: data stalls for 3 cycles while inst toggles.
        step(); data_req = 1; data_wr = 1; data_addr = 32'h8000_0020; inst_req = 1;
        inst_addr = 32'h1C00_0008; #1;
        chk("lk_c1_addr", mem_addr, 32'h8000_0020);
        chk("lk_c1_inst_ok", 32'(inst_addr_ok), 0);
        step(); inst_req = 0; #1;
        chk("lk_c2_state", 32'(dut.state), 32'(ARB_DATA));
        chk("lk_c2_addr", mem_addr, 32'h8000_0020);
        chk("lk_c2_wr", 32'(mem_wr), 1);
        step(); inst_req = 1; #1;
        chk("lk_c3_state", 32'(dut.state), 32'(ARB_DATA));
        chk("lk_c3_addr", mem_addr, 32'h8000_0020);
        chk("lk_c3_wr", 32'(mem_wr), 1);
        chk("lk_c3_inst_ok", 32'(inst_addr_ok), 0);
        step(); mem_addr_ok = 1; #1;
        chk("lk_release_data_ok", 32'(data_addr_ok), 1);
        chk("lk_release_inst_ok", 32'(inst_addr_ok), 0);
        step(); data_req = 0; data_wr = 0; #1;
        chk("lk_state_idle", 32'(dut.state), 32'(ARB_IDLE));
        chk("lk_inst_after", 32'(inst_addr_ok), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11; #1;
        chk("lk_resp1", {30'd0, data_data_ok, inst_data_ok}, 32'b10);
        step(); mem_rdata = 32'h22; #1;
        chk("lk_resp2", {30'd0, data_data_ok, inst_data_ok}, 32'b01);
        step(); mem_data_ok = 0; #1;
        chk("lk_cnt0", 32'(pending_cnt), 0);

        // Full: four inst reads accepted, the fifth is held off.
        for (int i = 0; i < 4; i++) begin
            step(); inst_req = 1; inst_addr = 32'h1C00_0100 + 32'(4 * i); mem_addr_ok = 1; #1;
            chk("fu_accept", 32'(inst_addr_ok), 1);
        end
        step(); inst_addr = 32'h1C00_0200; #1;
        chk("fu_cnt4", 32'(pending_cnt), 4);
        chk("fu_mem_req0", 32'(mem_req), 0);
        chk("fu_no_addr_ok", 32'(inst_addr_ok), 0);
        step(); mem_data_ok = 1; mem_rdata = 32'h33; #1;
        chk("fu_state_lock", 32'(dut.state), 32'(ARB_INST));
        chk("fu_still_blocked", 32'(mem_req), 0);
        chk("fu_pop_data_ok", 32'(inst_data_ok), 1);
        step(); mem_data_ok = 0; #1;
        chk("fu_cnt3", 32'(pending_cnt), 3);
        chk("fu_mem_req1", 32'(mem_req), 1);
        chk("fu_fifth_ok", 32'(inst_addr_ok), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
        chk("fu_cnt4b", 32'(pending_cnt), 4);
        step(); #1;
        step(); mem_data_ok = 0; #1;
        chk("pp_cnt2", 32'(pending_cnt), 2);

        // Simultaneous push (data) and pop (inst head) at count 2.
        step(); data_req = 1; data_addr = 32'h8000_0040; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h44; #1;
        chk("pp_push", 32'(data_addr_ok), 1);
        chk("pp_pop_inst", {30'd0, data_data_ok, inst_data_ok}, 32'b01);
        step(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; #1;
        chk("pp_cnt_same", 32'(pending_cnt), 2);
        step(); mem_data_ok = 1; mem_rdata = 32'h55; #1;
        chk("pp_order1", {30'd0, data_data_ok, inst_data_ok}, 32'b01);
        step(); mem_rdata = 32'h66; #1;
        chk("pp_order2", {30'd0, data_data_ok, inst_data_ok}, 32'b10);
        chk("pp_data_rdata", data_rdata, 32'h66);
        step(); #1;
        chk("sp_cnt0", 32'(pending_cnt), 0);
        chk("sp_no_data_ok", {30'd0, data_data_ok, inst_data_ok}, 0);
        step(); mem_data_ok = 0; #1;
        chk("sp_cnt_stays0", 32'(pending_cnt), 0);

        // Reset mid-lock with three outstanding.
        for (int i = 0; i < 3; i++) begin
            step(); inst_req = 1; inst_addr = 32'h1C00_0300 + 32'(4 * i); mem_addr_ok = 1;
        end
        step(); inst_req = 0; mem_addr_ok = 0; data_req = 1; data_addr = 32'h8000_0080; #1;
        chk("rs_cnt3", 32'(pending_cnt), 3);
        step(); #1;
        chk("rs_locked", 32'(dut.state), 32'(ARB_DATA));
        #1 resetn = 0; #1;
        chk("rs_mem_req", 32'(mem_req), 0);
        chk("rs_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("rs_cnt", 32'(pending_cnt), 0);
        chk("rs_rdata", inst_rdata | data_rdata, 0);
        step(); quiet(); resetn = 1;

        // Continuous dual requests: arbitration policy.
        step(); inst_req = 1; data_req = 1; inst_addr = 32'h1C00_0400; data_addr = 32'h8000_0400;
        mem_addr_ok = 1; #1;
`ifdef SRAM_ARB_RR_EN
        chk("arb_g1", 32'(data_addr_ok), 1);
        step(); #1;
        chk("arb_g2", 32'(inst_addr_ok), 1);
        step(); #1;
        chk("arb_g3", 32'(data_addr_ok), 1);
`else
        chk("arb_g1", 32'(data_addr_ok), 1);
        step(); #1;
        chk("arb_g2", 32'(data_addr_ok), 1);
        step(); #1;
        chk("arb_g3", 32'(inst_addr_ok), 0);
`endif
        step(); quiet();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU's instruction-fetch and data-access requesters, so the pipeline can run on a single unified memory interface.
- Sits between the IF/EX stage request ports and the shared memory bridge.
- Arbitrates address phases, tracks outstanding transactions in order and routes each data_ok/rdata back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; power of two, ≥2.
- OWNER_FIFO_AW, $clog2(MAX_OUTSTANDING), derived address width of the owner-tag FIFO.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req, inst_wr  in  1 each  instruction requester request / write flag
- inst_size  in  2  byte count: 0=1B, 1=2B, 2=4B
- inst_addr, inst_wdata  in  32 each
- inst_wstrb  in  4
- inst_addr_ok, inst_data_ok  out  1 each
- inst_rdata  out  32
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  same widths as inst_*
- data_addr_ok, data_data_ok  out  1 each
- data_rdata  out  32
- mem_req, mem_wr  out  1 each
- mem_size  out  2
- mem_addr, mem_wdata  out  32 each
- mem_wstrb  out  4
- mem_addr_ok, mem_data_ok  in  1 each
- mem_rdata  in  32
- pending_cnt  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count, for debug

Behaviour:
- Reset, asynchronous on resetn low:
  - state=ARB_IDLE, FIFO empty, pending_cnt=0.
  - mem_req=0; all *_addr_ok and *_data_ok = 0.
  - rdata outputs = 0.
- Handshakes:
  - Address phase completes in the cycle where req & addr_ok.
  - Data phase is a one-cycle data_ok pulse.
  - Requesters hold req and payload stable until addr_ok.
- FSM, registered grant:
  - ARB_IDLE: grant chosen combinationally. Fixed priority: data over inst.
    - Grant forwards the winner's payload to mem_*, with mem_req=1 if FIFO not full.
    - Winner has mem_addr_ok=1 that cycle: stay in ARB_IDLE.
    - Otherwise go to ARB_INST or ARB_DATA.
  - ARB_INST / ARB_DATA: grant locked to that owner, so mem_* stays stable regardless of the other requester. Return to ARB_IDLE on mem_addr_ok.
- Address-ok routing: granted requester's addr_ok = mem_addr_ok & mem_req; the other's addr_ok = 0.
- FIFO full (pending_cnt==MAX_OUTSTANDING):
  - mem_req=0, no addr_ok issued.
  - A lock state is kept while full.
- Accept: push owner tag (0=inst, 1=data) on mem_req & mem_addr_ok.
- Response:
  - On mem_data_ok with FIFO non-empty, pop head.
  - Assert head owner's data_ok for that cycle; drive its rdata = mem_rdata.
  - Other rdata holds its last value.
- Simultaneous push and pop in one cycle: pending_cnt unchanged, pointers both advance. A push into a full FIFO coinciding with a pop is not possible, because mem_req is 0 when full.
- mem_data_ok with FIFO empty: ignored. No data_ok pulses, count stays 0; a simulation-only assertion fires.
- Pointers wrap modulo MAX_OUTSTANDING. pending_cnt range is 0..MAX_OUTSTANDING.
- Responses are in strict issue order; no reordering.
- Reset mid-transaction: all tracking is dropped; the downstream bridge is reset by the same resetn.

Optional Feature:
- SRAM_ARB_RR_EN defined:
  - ARB_IDLE uses round-robin. A last_owner register (reset=inst) gives priority to the requester that did not win the last accepted transaction.
  - last_owner updates only on an accepted address phase.
- SRAM_ARB_RR_EN undefined: fixed data-over-inst priority; no last_owner register.

Decomposition:
- Package sram_arb_pkg:
  - Owner tag constants OWNER_INST=1'b0, OWNER_DATA=1'b1.
  - Arbiter state encoding ARB_IDLE/ARB_INST/ARB_DATA (2 bits).
  - Size codes SIZE_B/SIZE_H/SIZE_W.
- Sub-module owner_fifo: 1-bit-wide circular FIFO, depth MAX_OUTSTANDING, with push/pop/full/empty/count. Its async active-low reset is on resetn.

Test Plan:
- Single read: inst_req at addr 0x1C000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with 0xDEADBEEF -> inst_addr_ok 1 cycle, inst_data_ok 1 cycle, inst_rdata=0xDEADBEEF, data_* silent, pending_cnt 0→1→0.
- Conflict: inst_req and data_req (write 0x8000_0010, wstrb 4'hF) in the same cycle -> data granted first, inst next. data_data_ok precedes inst_data_ok in response order.
- Lock: data_req with mem_addr_ok held low 3 cycles while inst_req toggles -> mem_addr/mem_wr remain data's for all 3 cycles, state=ARB_DATA, inst_addr_ok=0.
- Full: 4 inst reads accepted with no data_ok -> pending_cnt=4, mem_req=0 on the 5th request. One mem_data_ok -> cnt 3, then the 5th is accepted.
- Simultaneous push/pop at cnt=2 -> cnt stays 2, order preserved. Spurious mem_data_ok at cnt=0 -> no data_ok outputs, assertion logged.
- resetn pulled low asynchronously mid-lock with cnt=3 -> outputs 0 immediately, state ARB_IDLE, cnt=0. With SRAM_ARB_RR_EN, alternating inst/data grants under continuous dual requests.
